elevator_ctrl_fsm: RTL and testbench

//  Elevator car sequencer for the 4-floor controller. Latches floor call

---
 rtl/elevator_ctrl_fsm.sv | 168 ++++++++++++++++
 tb/tb_elevator_ctrl_fsm.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl_fsm.sv
// Elevator car sequencer for a 4-floor building.
// Latches call buttons, schedules travel in SCAN order (keep direction while
// calls remain ahead), times floor-to-floor travel and door dwell, and tracks
// the car position by counting MOVE_TICKS per floor (no position sensors).
//
// Handshake: none. req is a level/pulse input sampled on every rising edge;
// all outputs are registered and change only on the rising edge.
module elevator_ctrl_fsm #(
   parameter int N_FLOORS   = 4,
   parameter int MOVE_TICKS = 100,
   parameter int DOOR_TICKS = 300
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [1:0] current_floor,
   output logic       moving,
   output logic       dir_up,
   output logic       door_open,
   output logic [3:0] pending
);

   localparam int MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
   localparam int CW        = $clog2(MAX_TICKS + 1);
   localparam int TOP_FLOOR = N_FLOORS - 1;

   localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS - 1);
   localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);
   localparam logic [1:0]    TOP       = 2'(TOP_FLOOR);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR_OPEN = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   logic [3:0] here_mask;
   logic [3:0] req_eff;
   logic [3:0] pend_set;
   logic       above;
   logic       below;
   logic       here;
   logic [1:0] step_floor;
   logic [3:0] step_mask;
   logic       arrive_hit;
   logic       ahead;
   logic       at_end;
   logic       door_restart;

   function automatic logic calls_above(input logic [3:0] p, input logic [1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > int'(f)) r = r | p[i];
      end
      return r;
   endfunction

   function automatic logic calls_below(input logic [3:0] p, input logic [1:0] f);
      logic r;
      r = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i < int'(f)) r = r | p[i];
      end
      return r;
   endfunction

   // Scheduling decisions derived from the registered call latch and position.
   always_comb begin
      here_mask    = 4'b0001 << current_floor;
      // A press at the floor whose door is open only extends the dwell.
      req_eff      = (state == DOOR_OPEN) ? (req & ~here_mask) : req;
      pend_set     = pending | req_eff;
      door_restart = (state == DOOR_OPEN) && (|(req & here_mask));
      above        = calls_above(pending, current_floor);
      below        = calls_below(pending, current_floor);
      here         = |(pending & here_mask);
      step_floor   = (state == MOVE_DOWN) ? (current_floor - 2'd1) : (current_floor + 2'd1);
      step_mask    = 4'b0001 << step_floor;
      arrive_hit   = |(pending & step_mask);
      ahead        = (state == MOVE_DOWN) ? calls_below(pending, step_floor)
                                          : calls_above(pending, step_floor);
      // Stepping past either end of the shaft is never allowed.
      at_end       = ((state == MOVE_UP)   && (current_floor == TOP)) ||
                     ((state == MOVE_DOWN) && (current_floor == 2'd0));
   end

   // Car sequencer: state, position, timers, call latch and registered flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         current_floor <= 2'd0;
         pending       <= 4'd0;
         moving        <= 1'b0;
         door_open     <= 1'b0;
         dir_up        <= 1'b1;
      end else begin
         // Later assignments in the branches below override this when a
         // door opens, so the clear wins over a same-edge press.
         pending <= pend_set;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (here) begin
                  state     <= DOOR_OPEN;
                  door_open <= 1'b1;
                  pending   <= pend_set & ~here_mask;
               end else if (dir_up && above) begin
                  state  <= MOVE_UP;
                  moving <= 1'b1;
               end else if (below) begin
                  state  <= MOVE_DOWN;
                  moving <= 1'b1;
                  dir_up <= 1'b0;
               end else if (above) begin
                  state  <= MOVE_UP;
                  moving <= 1'b1;
                  dir_up <= 1'b1;
               end
            end
            MOVE_UP, MOVE_DOWN: begin
               if (at_end) begin
                  state  <= IDLE;
                  moving <= 1'b0;
                  cnt    <= '0;
               end else if (cnt == MOVE_LAST) begin
                  cnt           <= '0;
                  current_floor <= step_floor;
                  if (arrive_hit) begin
                     state     <= DOOR_OPEN;
                     moving    <= 1'b0;
                     door_open <= 1'b1;
                     pending   <= pend_set & ~step_mask;
                  end else if (!ahead) begin
                     state  <= IDLE;
                     moving <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DOOR_OPEN: begin
               if (door_restart) begin
                  cnt <= '0;
               end else if (cnt == DOOR_LAST) begin
                  state     <= IDLE;
                  door_open <= 1'b0;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               moving    <= 1'b0;
               door_open <= 1'b0;
               cnt       <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_ctrl_fsm.sv
// Bench for elevator_ctrl_fsm with short timers (MOVE_TICKS=4, DOOR_TICKS=3).
// Each scenario pushes timestamped output snapshots, hand-derived from the
// sequencer behaviour, into a queue before driving its stimulus; a negedge
// monitor pops and compares them when their cycle comes round.
module tb_elevator_ctrl_fsm;

   localparam int M = 4;
   localparam int D = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'd0;
   logic [1:0] current_floor;
   logic       moving;
   logic       dir_up;
   logic       door_open;
   logic [3:0] pending;

   elevator_ctrl_fsm #(
      .N_FLOORS  (4),
      .MOVE_TICKS(M),
      .DOOR_TICKS(D)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .current_floor(current_floor),
      .moving       (moving),
      .dir_up       (dir_up),
      .door_open    (door_open),
      .pending      (pending)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) next_cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   // snapshot = {current_floor, moving, dir_up, door_open, pending}
   logic [8:0] exp_q[$];
   int         exp_cyc_q[$];
   string      exp_tag_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic expect_at(input int c, input string tag, input logic [1:0] f,
                            input logic mv, input logic du, input logic dr,
                            input logic [3:0] p);
      exp_cyc_q.push_back(c);
      exp_tag_q.push_back(tag);
      exp_q.push_back({f, mv, du, dr, p});
   endtask

   // Compare every expectation that falls due in the current cycle.
   always @(negedge clk) begin
      while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
         logic [8:0] e;
         string      t;
         e = exp_q.pop_front();
         t = exp_tag_q.pop_front();
         void'(exp_cyc_q.pop_front());
         check_eq(t, {23'd0, current_floor, moving, dir_up, door_open, pending}, {23'd0, e});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic press(input logic [3:0] r);
      req = r;
      next_cycle();
      req = 4'd0;
   endtask

   // ---------------- scenarios ----------------
   initial begin : stim
      int t0;
      int t1;
      int tt;

      // 1: reset held two cycles, then quiet.
      do_reset();
      t0 = cyc;
      for (int i = 0; i < 5; i++) expect_at(t0 + i, "rst_idle", 2'd0, 1'b0, 1'b1, 1'b0, 4'b0000);
      wait_until(t0 + 6);

      // 3: call at the current floor opens the door; re-press extends dwell.
      t0 = cyc;
      expect_at(t0 + 1,     "here_latch",   2'd0, 1'b0, 1'b1, 1'b0, 4'b0001);
      expect_at(t0 + 2,     "here_open",    2'd0, 1'b0, 1'b1, 1'b1, 4'b0000);
      expect_at(t0 + 4,     "repress_nolat", 2'd0, 1'b0, 1'b1, 1'b1, 4'b0000);
      expect_at(t0 + 2 + D, "dwell_extend", 2'd0, 1'b0, 1'b1, 1'b1, 4'b0000);
      expect_at(t0 + 3 + D, "dwell_last",   2'd0, 1'b0, 1'b1, 1'b1, 4'b0000);
      expect_at(t0 + 4 + D, "dwell_close",  2'd0, 1'b0, 1'b1, 1'b0, 4'b0000);
      press(4'b0001);
      wait_until(t0 + 3);
      press(4'b0001);
      wait_until(t0 + 6 + D);

      // 2: single call two floors up.
      t0 = cyc;
      expect_at(t0 + 1,             "up2_latch",  2'd0, 1'b0, 1'b1, 1'b0, 4'b0100);
      expect_at(t0 + 2,             "up2_start",  2'd0, 1'b1, 1'b1, 1'b0, 4'b0100);
      expect_at(t0 + 1 + M,         "up2_hold0",  2'd0, 1'b1, 1'b1, 1'b0, 4'b0100);
      expect_at(t0 + 2 + M,         "up2_floor1", 2'd1, 1'b1, 1'b1, 1'b0, 4'b0100);
      expect_at(t0 + 2 + 2 * M,     "up2_arrive", 2'd2, 1'b0, 1'b1, 1'b1, 4'b0000);
      expect_at(t0 + 1 + 2 * M + D, "up2_dwell",  2'd2, 1'b0, 1'b1, 1'b1, 4'b0000);
      expect_at(t0 + 2 + 2 * M + D, "up2_idle",   2'd2, 1'b0, 1'b1, 1'b0, 4'b0000);
      press(4'b0100);
      wait_until(t0 + 4 + 2 * M + D);

      // 4: from reset, call floor 3; call floor 0 arrives behind the car.
      do_reset();
      t0 = cyc;
      tt = t0 + 3 + 3 * M + D;
      expect_at(t0 + 1,         "scan_latch",  2'd0, 1'b0, 1'b1, 1'b0, 4'b1000);
      expect_at(t0 + 2,         "scan_start",  2'd0, 1'b1, 1'b1, 1'b0, 4'b1000);
      expect_at(t0 + 2 + M,     "scan_f1",     2'd1, 1'b1, 1'b1, 1'b0, 4'b1000);
      expect_at(t0 + 2 + 2 * M, "scan_f2",     2'd2, 1'b1, 1'b1, 1'b0, 4'b1001);
      expect_at(t0 + 2 + 3 * M, "scan_top",    2'd3, 1'b0, 1'b1, 1'b1, 4'b0001);
      expect_at(t0 + 2 + 3 * M + D, "scan_idle3", 2'd3, 1'b0, 1'b1, 1'b0, 4'b0001);
      expect_at(tt,             "scan_rev",    2'd3, 1'b1, 1'b0, 1'b0, 4'b0001);
      expect_at(tt + M,         "scan_dn2",    2'd2, 1'b1, 1'b0, 1'b0, 4'b0001);
      expect_at(tt + 2 * M,     "scan_dn1",    2'd1, 1'b1, 1'b0, 1'b0, 4'b0001);
      expect_at(tt + 3 * M,     "scan_bottom", 2'd0, 1'b0, 1'b0, 1'b1, 4'b0000);
      expect_at(tt + 3 * M + D, "scan_idle0",  2'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
      press(4'b1000);
      wait_until(t0 + 3 + M);
      press(4'b0001);
      wait_until(tt + 3 * M + D + 2);

      // 5: two calls ahead from floor 0 (last direction down): stop at 1, go on to 3.
      t0 = cyc;
      tt = t0 + 3 + M + D;
      expect_at(t0 + 1,         "two_latch", 2'd0, 1'b0, 1'b0, 1'b0, 4'b1010);
      expect_at(t0 + 2,         "two_start", 2'd0, 1'b1, 1'b1, 1'b0, 4'b1010);
      expect_at(t0 + 2 + M,     "two_stop1", 2'd1, 1'b0, 1'b1, 1'b1, 4'b1000);
      expect_at(t0 + 1 + M + D, "two_dwell", 2'd1, 1'b0, 1'b1, 1'b1, 4'b1000);
      expect_at(t0 + 2 + M + D, "two_idle1", 2'd1, 1'b0, 1'b1, 1'b0, 4'b1000);
      expect_at(tt,             "two_resume", 2'd1, 1'b1, 1'b1, 1'b0, 4'b1000);
      expect_at(tt + M,         "two_f2",    2'd2, 1'b1, 1'b1, 1'b0, 4'b1000);
      expect_at(tt + 2 * M,     "two_top",   2'd3, 1'b0, 1'b1, 1'b1, 4'b0000);
      expect_at(tt + 2 * M + D, "two_idle3", 2'd3, 1'b0, 1'b1, 1'b0, 4'b0000);
      press(4'b1010);
      wait_until(tt + 2 * M + D + 2);

      // 6: reset while travelling between floors 2 and 1, then serve floor 3.
      t0 = cyc;
      expect_at(t0 + 1,     "abort_latch",  2'd3, 1'b0, 1'b1, 1'b0, 4'b0001);
      expect_at(t0 + 2,     "abort_start",  2'd3, 1'b1, 1'b0, 1'b0, 4'b0001);
      expect_at(t0 + 2 + M, "abort_f2",     2'd2, 1'b1, 1'b0, 1'b0, 4'b0001);
      expect_at(t0 + 3 + M, "abort_rstcyc", 2'd2, 1'b1, 1'b0, 1'b0, 4'b0001);
      expect_at(t0 + 4 + M, "abort_reset",  2'd0, 1'b0, 1'b1, 1'b0, 4'b0000);
      expect_at(t0 + 7 + M, "abort_stay",   2'd0, 1'b0, 1'b1, 1'b0, 4'b0000);
      press(4'b0001);
      wait_until(t0 + 3 + M);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      wait_until(t0 + 8 + M);

      t1 = cyc;
      expect_at(t1 + 1,             "post_latch", 2'd0, 1'b0, 1'b1, 1'b0, 4'b1000);
      expect_at(t1 + 2,             "post_start", 2'd0, 1'b1, 1'b1, 1'b0, 4'b1000);
      expect_at(t1 + 2 + M,         "post_f1",    2'd1, 1'b1, 1'b1, 1'b0, 4'b1000);
      expect_at(t1 + 2 + 2 * M,     "post_f2",    2'd2, 1'b1, 1'b1, 1'b0, 4'b1000);
      expect_at(t1 + 2 + 3 * M,     "post_top",   2'd3, 1'b0, 1'b1, 1'b1, 4'b0000);
      expect_at(t1 + 2 + 3 * M + D, "post_idle",  2'd3, 1'b0, 1'b1, 1'b0, 4'b0000);
      press(4'b1000);
      wait_until(t1 + 4 + 3 * M + D);

      // Every queued expectation must have been consumed.
      check_eq("drain", exp_q.size(), 0);

      // ---------------- final report ----------------
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Safety net: the scenario list is cycle-bounded, so this should never fire.
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
